pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

- Sequences the five-stage pipeline's register write-enables and flushes.
- Combines the hazard unit's `cHazard`/`dHazard` with a multi-cycle data-memory request/acknowledge handshake.
- Freezes the pipeline during memory waits and watchdogs the memory with a timeout.
- Sits between the hazard unit, data-memory port and all pipeline registers; keeps a saturating stall-cycle counter for performance reporting.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum MEM_WAIT cycles without `memAck` before entering ERROR; legal range ≥ 2.
- `CNT_W`, default 32: width of `stallCycles`.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `dHazard` in 1: data hazard from the hazard unit (load-use / branch operand not ready).
- `cHazard` in 1: branch taken, resolved in ID.
- `memReq` in 1: MEM-stage instruction is a load/store needing data memory.
- `memAck` in 1: data memory done, one-cycle pulse; load data valid in the same cycle.
- `memStrobe` out 1: one-cycle request pulse to data memory.
- `pcWrEnable`, `ifidWrEnable`, `idexWrEnable`, `exmemWrEnable`, `memwbWrEnable` out 1 each: pipeline register enables.
- `ifidFlush` out 1: clear IF/ID to NOP on the next edge.
- `idexFlush` out 1: insert a bubble into ID/EX on the next edge.
- `memTimeout` out 1: sticky error flag.
- `stallCycles` out CNT_W: saturating count of cycles with `pcWrEnable`=0, ERROR excluded.

## Operation
- States: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- All outputs except `memTimeout` and `stallCycles` are combinational from state and inputs.
- While `rst`=1: all enables, flushes and `memStrobe` are 0; next state RUN; `waitCount`=0, `memTimeout`=0, `stallCycles`=0.
- RUN, priority highest first:
  - `memReq`=1: `memStrobe`=1; all five enables 0; flushes 0; next MEM_WAIT; `waitCount` cleared to 0. Hazards are ignored this cycle and re-evaluated after release.
  - else `dHazard`=1: `pcWrEnable`=`ifidWrEnable`=0; `idexWrEnable`=1 with `idexFlush`=1; `exmemWrEnable`=`memwbWrEnable`=1. `cHazard` is ignored, since the branch cannot resolve with stale operands.
  - else `cHazard`=1: all enables 1; `ifidFlush`=1.
  - else: all enables 1; flushes 0.
- MEM_WAIT:
  - `memAck`=1: all five enables 1, so MEM/WB captures load data; flushes 0; next RUN.
  - `memAck`=0 and `waitCount`==TIMEOUT_CYCLES−1: enables 0; next ERROR.
  - otherwise: enables 0; `waitCount`++.
  - `memReq` and hazards are ignored; `memStrobe` is never re-asserted.
- ERROR: all enables, flushes and `memStrobe` are 0. `memTimeout`=1 is registered on entry and held until `rst`. Only `rst` exits.
- `memAck` outside MEM_WAIT is ignored.
- `stallCycles`: increments each non-reset cycle where state≠ERROR and `pcWrEnable`=0; saturates at all-ones.
- `waitCount` width is $clog2(TIMEOUT_CYCLES).

## Timing
- Memory access takes at least 2 cycles: strobe cycle in RUN, then ack no earlier than the first MEM_WAIT cycle.
- Pipeline advances in the ack cycle. The next `memReq` is evaluated in RUN on the following cycle; back-to-back memory ops therefore cost strobe + wait + ack.
- `dHazard` stall lasts exactly as long as `dHazard` is held; each held cycle inserts one bubble.
- An ack arriving in the final allowed cycle (`waitCount`==TIMEOUT_CYCLES−1) wins over timeout: next state RUN, no error.
- `memTimeout` rises on the first ERROR cycle, which is TIMEOUT_CYCLES+1 cycles after the strobe.
- `rst` asserted in MEM_WAIT or ERROR returns to RUN on the next edge; any outstanding request is abandoned and `memStrobe` stays 0 during `rst`.

## Test plan
- Reset: hold `rst` 2 cycles with `memReq`=1 and `dHazard`=1 → all enables/flushes/`memStrobe` 0; after release, `stallCycles`=0 and `memTimeout`=0.
- Load with ack 3 cycles after strobe → `memStrobe` high for 1 cycle; enables 0 for 3 cycles; all enables 1 in the ack cycle; `stallCycles`=3.
- `dHazard` and `cHazard` both high 1 cycle, then `cHazard` alone 1 cycle → cycle 1: pc/ifid hold, `idexFlush`=1, `ifidFlush`=0; cycle 2: all enables 1, `ifidFlush`=1.
- `memReq` together with `dHazard` → memory path taken (`memStrobe`=1, no `idexFlush`); `dHazard` still high after ack → bubble inserted the cycle after release.
- TIMEOUT_CYCLES=4:
  - ack on the 4th MEM_WAIT cycle → back to RUN, `memTimeout`=0.
  - no ack → ERROR on the cycle after the 4th wait; `memTimeout`=1 sticky; a later `memAck` has no effect; `rst` clears it.
- CNT_W=4 with a 20-cycle `dHazard` → `stallCycles` saturates at 15; a stray `memAck` in RUN causes no state change.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle between the pipeline controller and its environment
// (hazard unit, data-memory port and the pipeline registers).
//
// Signals:
//   dHazard        data hazard from the hazard unit (load-use / operand not ready)
//   cHazard        taken branch resolved in ID
//   memReq         MEM-stage instruction needs data memory
//   memAck         data memory done, one-cycle pulse, load data valid same cycle
//   memStrobe      one-cycle request pulse to data memory
//   pcWrEnable .. memwbWrEnable  pipeline register write enables
//   ifidFlush      clear IF/ID to NOP on the next edge
//   idexFlush      insert a bubble into ID/EX on the next edge
//   memTimeout     sticky memory-timeout error flag
//   stallCycles    saturating count of stalled cycles
//
// Modports:
//   master  the controller side (drives strobe, enables, flushes, status)
//   slave   the environment side (drives hazards and the memory handshake)
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             dHazard;
    logic             cHazard;
    logic             memReq;
    logic             memAck;
    logic             memStrobe;
    logic             pcWrEnable;
    logic             ifidWrEnable;
    logic             idexWrEnable;
    logic             exmemWrEnable;
    logic             memwbWrEnable;
    logic             ifidFlush;
    logic             idexFlush;
    logic             memTimeout;
    logic [CNT_W-1:0] stallCycles;

    modport master (
        input  dHazard,
        input  cHazard,
        input  memReq,
        input  memAck,
        output memStrobe,
        output pcWrEnable,
        output ifidWrEnable,
        output idexWrEnable,
        output exmemWrEnable,
        output memwbWrEnable,
        output ifidFlush,
        output idexFlush,
        output memTimeout,
        output stallCycles
    );

    modport slave (
        output dHazard,
        output cHazard,
        output memReq,
        output memAck,
        input  memStrobe,
        input  pcWrEnable,
        input  ifidWrEnable,
        input  idexWrEnable,
        input  exmemWrEnable,
        input  memwbWrEnable,
        input  ifidFlush,
        input  idexFlush,
        input  memTimeout,
        input  stallCycles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller.
//
// Sequences the pipeline register write-enables and flushes from the hazard
// unit's dHazard/cHazard and a multi-cycle data-memory request/ack handshake.
// The pipeline is frozen while a memory access is outstanding; a watchdog
// moves to a sticky error state if no ack arrives within TIMEOUT_CYCLES
// wait cycles. A saturating counter records stalled (pc held) cycles.
//
// Parameters:
//   TIMEOUT_CYCLES  max MEM_WAIT cycles without memAck before ERROR (>= 2)
//   CNT_W           width of stallCycles
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-high reset
//   bus   pipeline_ctrl_if master modport (hazards, memory handshake,
//         pipeline enables/flushes, memTimeout, stallCycles)
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 32
) (
    input logic            clk,
    input logic            rst,
    pipeline_ctrl_if.master bus
);

    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StError
    } state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_count_q, wait_count_d;
    logic             mem_timeout_q;
    logic [CNT_W-1:0] stall_cycles_q;

    logic mem_strobe;
    logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic ifid_flush, idex_flush;

    // Next-state and combinational outputs.
    always_comb begin
        state_d      = state_q;
        wait_count_d = wait_count_q;
        mem_strobe   = 1'b0;
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        idex_we      = 1'b0;
        exmem_we     = 1'b0;
        memwb_we     = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;

        if (rst) begin
            state_d      = StRun;
            wait_count_d = '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.memReq) begin
                        // Memory takes priority; hazards are re-evaluated after release.
                        mem_strobe   = 1'b1;
                        state_d      = StMemWait;
                        wait_count_d = '0;
                    end else if (bus.dHazard) begin
                        // Hold PC and IF/ID, bubble into ID/EX. A simultaneous
                        // cHazard is dropped: the branch used stale operands.
                        idex_we    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                    end else if (bus.cHazard) begin
                        pc_we      = 1'b1;
                        ifid_we    = 1'b1;
                        idex_we    = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                        ifid_flush = 1'b1;
                    end else begin
                        pc_we    = 1'b1;
                        ifid_we  = 1'b1;
                        idex_we  = 1'b1;
                        exmem_we = 1'b1;
                        memwb_we = 1'b1;
                    end
                end
                StMemWait: begin
                    if (bus.memAck) begin
                        // Ack wins even in the final allowed cycle; MEM/WB captures data.
                        pc_we    = 1'b1;
                        ifid_we  = 1'b1;
                        idex_we  = 1'b1;
                        exmem_we = 1'b1;
                        memwb_we = 1'b1;
                        state_d  = StRun;
                    end else if (wait_count_q == WaitLast) begin
                        state_d = StError;
                    end else begin
                        wait_count_d = wait_count_q + 1'b1;
                    end
                end
                StError: begin
                    // Frozen until reset.
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StRun;
            wait_count_q   <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_count_q <= wait_count_d;
            if (state_d == StError) begin
                mem_timeout_q <= 1'b1;
            end
            // ERROR cycles are not counted; the counter sticks at all-ones.
            if (state_q != StError && !pc_we && stall_cycles_q != {CNT_W{1'b1}}) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
        end
    end

    assign bus.memStrobe     = mem_strobe;
    assign bus.pcWrEnable    = pc_we;
    assign bus.ifidWrEnable  = ifid_we;
    assign bus.idexWrEnable  = idex_we;
    assign bus.exmemWrEnable = exmem_we;
    assign bus.memwbWrEnable = memwb_we;
    assign bus.ifidFlush     = ifid_flush;
    assign bus.idexFlush     = idex_flush;
    assign bus.memTimeout    = mem_timeout_q;
    assign bus.stallCycles   = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with TIMEOUT_CYCLES=4, CNT_W=4.
// Inputs change at the falling edge; outputs are sampled 1 time unit later.
module tb_pipeline_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipeline_ctrl_if #(.CNT_W(4)) bus ();

    pipeline_ctrl #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply one cycle of stimulus.
    task automatic cyc(input logic r, input logic mr, input logic ma,
                       input logic dh, input logic ch);
        @(negedge clk);
        rst         = r;
        bus.memReq  = mr;
        bus.memAck  = ma;
        bus.dHazard = dh;
        bus.cHazard = ch;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] en();
        return {bus.pcWrEnable, bus.ifidWrEnable, bus.idexWrEnable,
                bus.exmemWrEnable, bus.memwbWrEnable};
    endfunction

    // {memStrobe, ifidFlush, idexFlush}
    function automatic logic [2:0] ctl();
        return {bus.memStrobe, bus.ifidFlush, bus.idexFlush};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.memReq  = 1'b0;
        bus.memAck  = 1'b0;
        bus.dHazard = 1'b0;
        bus.cHazard = 1'b0;

        // Reset held 2 cycles with memReq and dHazard active.
        cyc(1, 1, 0, 1, 0);
        chk("rst1_en", 32'(en()), 32'h00);
        chk("rst1_ctl", 32'(ctl()), 32'h0);
        cyc(1, 1, 0, 1, 0);
        chk("rst2_en", 32'(en()), 32'h00);
        chk("rst2_ctl", 32'(ctl()), 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("rel_stall", 32'(bus.stallCycles), 32'd0);
        chk("rel_timeout", 32'(bus.memTimeout), 32'd0);
        chk("rel_en", 32'(en()), 32'h1f);
        chk("rel_ctl", 32'(ctl()), 32'h0);

        // Load, ack 3 cycles after the strobe.
        cyc(0, 1, 0, 0, 0);
        chk("ld_strobe_en", 32'(en()), 32'h00);
        chk("ld_strobe_ctl", 32'(ctl()), 32'h4);
        cyc(0, 0, 0, 0, 0);
        chk("ld_w0_en", 32'(en()), 32'h00);
        chk("ld_w0_ctl", 32'(ctl()), 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("ld_w1_en", 32'(en()), 32'h00);
        cyc(0, 0, 1, 0, 0);
        chk("ld_ack_en", 32'(en()), 32'h1f);
        chk("ld_ack_ctl", 32'(ctl()), 32'h0);
        chk("ld_stall", 32'(bus.stallCycles), 32'd3);
        cyc(0, 0, 0, 0, 0);
        chk("ld_after_en", 32'(en()), 32'h1f);
        chk("ld_after_stall", 32'(bus.stallCycles), 32'd3);

        // dHazard+cHazard, then cHazard alone.
        cyc(0, 0, 0, 1, 1);
        chk("dc_en", 32'(en()), 32'h07);
        chk("dc_ctl", 32'(ctl()), 32'h1);
        cyc(0, 0, 0, 0, 1);
        chk("c_en", 32'(en()), 32'h1f);
        chk("c_ctl", 32'(ctl()), 32'h2);
        chk("c_stall", 32'(bus.stallCycles), 32'd4);

        // memReq with dHazard: memory wins, bubble after release.
        cyc(0, 1, 0, 1, 0);
        chk("md_en", 32'(en()), 32'h00);
        chk("md_ctl", 32'(ctl()), 32'h4);
        cyc(0, 0, 1, 1, 0);
        chk("md_ack_en", 32'(en()), 32'h1f);
        chk("md_ack_ctl", 32'(ctl()), 32'h0);
        cyc(0, 0, 0, 1, 0);
        chk("md_bubble_en", 32'(en()), 32'h07);
        chk("md_bubble_ctl", 32'(ctl()), 32'h1);
        cyc(0, 0, 0, 0, 0);
        chk("md_idle_en", 32'(en()), 32'h1f);
        chk("md_stall", 32'(bus.stallCycles), 32'd6);

        // Ack on the 4th (final) wait cycle wins over timeout.
        cyc(0, 1, 0, 0, 0);
        chk("late_strobe_ctl", 32'(ctl()), 32'h4);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk("late_wait_en", 32'(en()), 32'h00);
        end
        cyc(0, 0, 1, 0, 0);
        chk("late_ack_en", 32'(en()), 32'h1f);
        cyc(0, 0, 0, 0, 0);
        chk("late_run_en", 32'(en()), 32'h1f);
        chk("late_timeout", 32'(bus.memTimeout), 32'd0);
        chk("late_stall", 32'(bus.stallCycles), 32'd10);

        // Timeout from a clean counter.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("to_strobe_ctl", 32'(ctl()), 32'h4);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk("to_wait_en", 32'(en()), 32'h00);
            chk("to_wait_timeout", 32'(bus.memTimeout), 32'd0);
        end
        cyc(0, 0, 0, 0, 0);
        chk("to_err_timeout", 32'(bus.memTimeout), 32'd1);
        chk("to_err_en", 32'(en()), 32'h00);
        chk("to_err_stall", 32'(bus.stallCycles), 32'd5);
        cyc(0, 1, 1, 1, 1);
        chk("to_err_in_en", 32'(en()), 32'h00);
        chk("to_err_in_ctl", 32'(ctl()), 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("to_sticky", 32'(bus.memTimeout), 32'd1);
        chk("to_err_en2", 32'(en()), 32'h00);
        chk("to_err_stall2", 32'(bus.stallCycles), 32'd5);
        cyc(1, 0, 0, 0, 0);
        chk("to_rst_en", 32'(en()), 32'h00);
        cyc(0, 0, 0, 0, 0);
        chk("to_clr_timeout", 32'(bus.memTimeout), 32'd0);
        chk("to_clr_stall", 32'(bus.stallCycles), 32'd0);
        chk("to_clr_en", 32'(en()), 32'h1f);

        // Stray ack in RUN, then saturate the counter with a long dHazard.
        cyc(0, 0, 1, 0, 0);
        chk("stray_en", 32'(en()), 32'h1f);
        chk("stray_ctl", 32'(ctl()), 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("stray_next_en", 32'(en()), 32'h1f);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk("sat_en", 32'(en()), 32'h07);
            chk("sat_cnt", 32'(bus.stallCycles), (i < 15) ? 32'(i) : 32'd15);
        end
        cyc(0, 0, 0, 0, 0);
        chk("sat_final", 32'(bus.stallCycles), 32'd15);

        // Reset during MEM_WAIT abandons the request.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rw_wait_en", 32'(en()), 32'h00);
        cyc(1, 1, 0, 0, 0);
        chk("rw_rst_en", 32'(en()), 32'h00);
        chk("rw_rst_ctl", 32'(ctl()), 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("rw_run_en", 32'(en()), 32'h1f);
        chk("rw_run_stall", 32'(bus.stallCycles), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
